// File: rtl/remap_pkg.sv
// Shared constants for the antilog remap datapath: segment/top-field widths and
// the per-segment correction subtrahends applied to the Mitchell fraction.
package remap_pkg;
  localparam int SEG_W = 2;
  localparam int TOP_W = 10;

  // Index 0 is the lowest segment; C_CORR[seg] is subtracted from the top field.
  localparam logic [3:0][TOP_W-1:0] C_CORR = {10'd42, 10'd85, 10'd80, 10'd35};
endpackage

// File: rtl/m_antilog_correct.sv
// Piecewise fraction correction for the Mitchell antilog; enabled by the macro
// REMAP_ANTILOG_CORRECTION_EN, otherwise the fraction passes through unchanged.
module m_antilog_correct
  import remap_pkg::*;
#(
  parameter int wl_f = 31
) (
  input  logic [wl_f-1:0] IN_F,
  output logic [wl_f-1:0] OUT_F
);
`ifdef REMAP_ANTILOG_CORRECTION_EN
  logic [SEG_W-1:0] seg;
  logic [TOP_W-1:0] t, c, t_c;

  assign seg = IN_F[wl_f-1 -: SEG_W];
  assign t   = IN_F[wl_f-1 -: TOP_W];
  assign c   = C_CORR[seg];
  // Only segment 0 can underflow (t < 35); clamp keeps the mantissa in [1,2).
  assign t_c = (t >= c) ? (t - c) : '0;

  assign OUT_F = {t_c, IN_F[wl_f-TOP_W-1:0]};
`else
  assign OUT_F = IN_F;
`endif
endmodule

// File: rtl/m_antilog_pipe.sv
// Three-stage Mitchell antilog: S1 input reg, S2 correction + mantissa, S3 shift.
// Optional fraction correction is built when REMAP_ANTILOG_CORRECTION_EN is defined.
module m_antilog_pipe #(
  parameter int wl_f   = 31,
  parameter int wl_k   = 5,
  parameter int wl_out = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_ZERO,
  input  logic [wl_k-1:0]   IN_K,
  input  logic [wl_f-1:0]   IN_F,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [wl_out-1:0] OUT_DATA
);
  localparam int MW = wl_f + 1 + (1 << wl_k);

  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3, acc;

  logic              z1_q, z2_q;
  logic [wl_k-1:0]   k1_q, k2_q;
  logic [wl_f-1:0]   f1_q, fc;
  logic [wl_f:0]     m2_q;
  logic [MW-1:0]     m_ext;
  logic [wl_out-1:0] out_d, out_q;

  // A stage advances when it holds data and the next stage is empty or advancing,
  // so bubbles compact even while the output is stalled.
  assign adv3     = v3_q & OUT_READY;
  assign adv2     = v2_q & (~v3_q | adv3);
  assign adv1     = v1_q & (~v2_q | adv2);
  assign IN_READY = ~v1_q | adv1;
  assign acc      = IN_VALID & IN_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= acc  | (v1_q & ~adv1);
      v2_q <= adv1 | (v2_q & ~adv2);
      v3_q <= adv2 | (v3_q & ~adv3);
    end
  end

  always_ff @(posedge CLK) begin
    if (acc) begin
      z1_q <= IN_ZERO;
      k1_q <= IN_K;
      f1_q <= IN_F;
    end
  end

  m_antilog_correct #(.wl_f(wl_f)) u_corr (
    .IN_F (f1_q),
    .OUT_F(fc)
  );

  always_ff @(posedge CLK) begin
    if (adv1) begin
      z2_q <= z1_q;
      k2_q <= k1_q;
      m2_q <= {1'b1, fc};
    end
  end

  assign m_ext = {{(MW-wl_f-1){1'b0}}, m2_q};

  always_comb begin
    out_d = wl_out'((m_ext << k2_q) >> wl_f);
    if (z2_q) out_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    out_q <= '0;
    else if (adv2) out_q <= out_d;
  end

  assign OUT_VALID = v3_q;
  assign OUT_DATA  = out_q;
endmodule

// File: tb/tb_m_antilog_pipe.sv
// Directed bench for m_antilog_pipe; expected values follow the build selected
// by REMAP_ANTILOG_CORRECTION_EN.
module tb_m_antilog_pipe;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        IN_ZERO = 1'b0;
  logic [4:0]  IN_K = '0;
  logic [30:0] IN_F = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_DATA;

  int err_cnt = 0;
  int chk_cnt = 0;

  m_antilog_pipe #(.wl_f(31), .wl_k(5), .wl_out(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_ZERO(IN_ZERO), .IN_K(IN_K), .IN_F(IN_F), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
  );

  always #5 CLK = ~CLK;

`ifdef REMAP_ANTILOG_CORRECTION_EN
  localparam logic [31:0] EXP_HALF = 32'd1451;
  localparam logic [31:0] EXP_MAX  = 32'hFABF_FFFF;
`else
  localparam logic [31:0] EXP_HALF = 32'd1536;
  localparam logic [31:0] EXP_MAX  = 32'hFFFF_FFFF;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated beat with OUT_READY high; checks exact 3-cycle latency.
  task automatic run_beat(input string tag, input logic z, input logic [4:0] k,
                          input logic [30:0] f, input logic [31:0] exp);
    @(negedge CLK);
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_ZERO = z; IN_K = k; IN_F = f;
    #1 chk({tag, "_rdy"}, 64'(IN_READY), 64'd1);
    @(negedge CLK); IN_VALID = 1'b0; IN_ZERO = 1'b0;
    #1 chk({tag, "_c1"}, 64'(OUT_VALID), 64'd0);
    @(negedge CLK);
    #1 chk({tag, "_c2"}, 64'(OUT_VALID), 64'd0);
    @(negedge CLK);
    #1 chk({tag, "_c3vld"}, 64'(OUT_VALID), 64'd1);
    chk({tag, "_data"}, 64'(OUT_DATA), 64'(exp));
    @(negedge CLK);
    #1 chk({tag, "_drain"}, 64'(OUT_VALID), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_s [10];
    int sent, rcv, drop_at, cyc;
    logic prev_stall;
    logic [31:0] prev_data;

    for (int i = 0; i < 10; i++) exp_s[i] = 32'd1 << i;

    #12;
    chk("rst_vld", 64'(OUT_VALID), 64'd0);
    chk("rst_rdy", 64'(IN_READY), 64'd1);
    chk("rst_data", 64'(OUT_DATA), 64'd0);
    @(negedge CLK); RST_N = 1'b1;

    run_beat("k0f0", 1'b0, 5'd0, 31'd0, 32'd1);
    run_beat("half", 1'b0, 5'd10, 31'h4000_0000, EXP_HALF);
    run_beat("max", 1'b0, 5'd31, 31'h7FFF_FFFF, EXP_MAX);
    run_beat("clamp", 1'b0, 5'd5, 31'd0, 32'd32);
    run_beat("zero", 1'b1, 5'd20, 31'h1234_5678, 32'd0);

    // Streaming: OUT_READY low for the first 4 cycles, then high.
    sent = 0; rcv = 0; drop_at = -1; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (rcv < 10 && cyc < 60) begin
      @(negedge CLK);
      OUT_READY = (cyc >= 4);
      IN_VALID  = (sent < 10);
      IN_K      = 5'(sent);
      IN_F      = '0;
      #1;
      if (prev_stall) begin
        chk("stall_vld", 64'(OUT_VALID), 64'd1);
        chk("stall_data", 64'(OUT_DATA), 64'(prev_data));
      end
      if (IN_VALID && !IN_READY && drop_at < 0) drop_at = sent;
      if (OUT_VALID && OUT_READY) begin
        chk($sformatf("stream%0d", rcv), 64'(OUT_DATA), 64'(exp_s[rcv]));
        rcv++;
      end
      if (IN_VALID && IN_READY) sent++;
      prev_stall = OUT_VALID & ~OUT_READY;
      prev_data  = OUT_DATA;
      cyc++;
    end
    chk("stream_drop_at", 64'(drop_at), 64'd3);
    chk("stream_count", 64'(rcv), 64'd10);
    @(negedge CLK); IN_VALID = 1'b0;
    @(negedge CLK);
    #1 chk("stream_extra", 64'(OUT_VALID), 64'd0);

    // Mid-stream reset with three beats in flight.
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); IN_VALID = 1'b1; IN_K = 5'(i + 1); IN_F = '0;
    end
    @(negedge CLK); IN_VALID = 1'b0;
    #1 chk("pre_rst_vld", 64'(OUT_VALID), 64'd1);
    #1 RST_N = 1'b0;
    #1 chk("mid_rst_vld", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_rdy", 64'(IN_READY), 64'd1);
    chk("mid_rst_data", 64'(OUT_DATA), 64'd0);
    @(negedge CLK); RST_N = 1'b1; OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1 chk($sformatf("post_rst_idle%0d", i), 64'(OUT_VALID), 64'd0);
    end
    run_beat("post_rst", 1'b0, 5'd3, 31'd0, 32'd8);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
